// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: RISC-V immediate generator with a valid/ready handshake on
// both sides. R0 is the output register and R1 is a one-deep skid register.
// The skid register lets the block accept at full rate while in_ready is
// taken straight from a flop, so out_ready has no combinational path to it.
module imm_ext_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [15:0]      illegal_cnt
);

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_U   = 3'b011;
    localparam logic [2:0] FMT_J   = 3'b100;
    localparam logic [2:0] FMT_SH  = 3'b101;
    localparam logic [2:0] FMT_BAD = 3'b110;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } rsp_t;

    logic [2:0]        w_fmt;
    logic signed [31:0] w_imm32;
    logic              w_ill;
    rsp_t              w_new;
    logic              w_acc;
    logic              w_r0_free;

    rsp_t              r_r0;
    rsp_t              r_r1;
    logic              r_r0_vld;
    logic              r_r1_vld;
    logic [15:0]       r_illegal_cnt;

    // Format select: explicit imm_src, or derived from opcode/funct3.
    always_comb begin
        w_fmt = imm_src;
        if (AUTO_DECODE != 0) begin
            case (instruction[6:0])
                // funct3 001/101 are the shift-immediate ops.
                7'b0010011: w_fmt = (instruction[13:12] == 2'b01) ? FMT_SH : FMT_I;
                7'b0000011,
                7'b1100111,
                7'b1110011: w_fmt = FMT_I;
                7'b0100011: w_fmt = FMT_S;
                7'b1100011: w_fmt = FMT_B;
                7'b0110111,
                7'b0010111: w_fmt = FMT_U;
                7'b1101111: w_fmt = FMT_J;
                default:    w_fmt = FMT_BAD;
            endcase
        end
    end

    // Build a 32-bit signed immediate; widening to XLEN below sign-extends it.
    // SHAMT is built non-negative so the widening leaves it zero-extended.
    always_comb begin
        w_ill   = 1'b0;
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:   w_imm32 = 32'($signed(instruction[31:20]));
            FMT_S:   w_imm32 = 32'($signed({instruction[31:25], instruction[11:7]}));
            FMT_B:   w_imm32 = 32'($signed({instruction[31], instruction[7],
                                             instruction[30:25], instruction[11:8], 1'b0}));
            FMT_U:   w_imm32 = {instruction[31:12], 12'b0};
            FMT_J:   w_imm32 = 32'($signed({instruction[31], instruction[19:12],
                                             instruction[20], instruction[30:21], 1'b0}));
            FMT_SH:  w_imm32 = (XLEN == 64) ? {26'b0, instruction[25:20]}
                                            : {27'b0, instruction[24:20]};
            default: w_ill   = 1'b1;
        endcase
    end

    assign w_new.imm = XLEN'(w_imm32);
    assign w_new.tag = in_tag;
    assign w_new.ill = w_ill;

    assign in_ready  = !r_r1_vld;
    assign w_acc     = in_valid && in_ready;
    // R0 can take new contents when it is empty or its current word leaves now.
    assign w_r0_free = !r_r0_vld || out_ready;

    // Output register: refilled from R1 first to keep order, else from input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r0     <= '0;
            r_r0_vld <= 1'b0;
        end else if (w_r0_free) begin
            if (r_r1_vld) begin
                r_r0     <= r_r1;
                r_r0_vld <= 1'b1;
            end else if (w_acc) begin
                r_r0     <= w_new;
                r_r0_vld <= 1'b1;
            end else begin
                r_r0_vld <= 1'b0;
            end
        end
    end

    // Skid register: catches an accept that arrives while R0 is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r1     <= '0;
            r_r1_vld <= 1'b0;
        end else if (w_acc && !w_r0_free) begin
            r_r1     <= w_new;
            r_r1_vld <= 1'b1;
        end else if (r_r1_vld && out_ready) begin
            r_r1_vld <= 1'b0;
        end
    end

    // Saturating count of accepted illegal-format instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_acc && w_new.ill && (r_illegal_cnt != 16'hFFFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end
    end

    assign out_valid   = r_r0_vld;
    assign imm_data    = r_r0.imm;
    assign out_tag     = r_r0.tag;
    assign out_illegal = r_r0.ill;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three instances (XLEN=32, XLEN=64, auto-decode)
// share one input stream; a scoreboard queue holds expected outputs.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [2:0]  imm_src = '0;
    logic [4:0]  in_tag = '0;
    logic        out_ready = 1'b0;
    int          or_mode = 0;   // 0: hold low, 1: hold high, 2: random

    logic        rdy32, rdy64, rdyau;
    logic        v32, v64, vau;
    logic [31:0] imm32, immau;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64, tagau;
    logic        ill32, ill64, illau;
    logic [15:0] cnt32, cnt64, cntau;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
        logic [31:0] eau;
        logic        illau;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
        logic [31:0] eau;
        logic        illau;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[20];

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(5)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready), .imm_data(imm32),
        .out_tag(tag32), .out_illegal(ill32), .illegal_cnt(cnt32));

    imm_ext_pipe #(.XLEN(64), .AUTO_DECODE(0), .TAG_W(5)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(v64), .out_ready(out_ready), .imm_data(imm64),
        .out_tag(tag64), .out_illegal(ill64), .illegal_cnt(cnt64));

    imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(5)) uau (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyau),
        .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(vau), .out_ready(out_ready), .imm_data(immau),
        .out_tag(tagau), .out_illegal(illau), .illegal_cnt(cntau));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor: compare every completed output transfer.
    always @(negedge clk) begin
        if (!rst && v32 && out_ready) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got tag %0d expected none", tag32);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid64_vs_32", {63'b0, v64 & vau}, 64'd1);
                chk("tag32",  {59'b0, tag32}, {59'b0, e.tag});
                chk("imm32",  {31'b0, ill32, imm32}, {31'b0, e.ill, e.e32});
                chk("imm64",  imm64, e.e64);
                chk("ill64",  {58'b0, tag64, ill64}, {58'b0, e.tag, e.ill});
                chk("immau",  {26'b0, tagau, illau, immau}, {26'b0, e.tag, e.illau, e.eau});
            end
        end
    end

    task automatic send(input vec_t v, input logic [4:0] tag, output int stalls);
        exp_t e;
        bit   acc;
        e = '{tag, v.e32, v.e64, v.ill, v.eau, v.illau};
        in_valid = 1'b1; instruction = v.inst; imm_src = v.src; in_tag = tag;
        stalls = 0;
        acc = 0;
        while (!acc) begin
            @(negedge clk);
            if (rdy32) acc = 1;
            else begin
                stalls++;
                if (stalls > 200) begin
                    errors++;
                    $display("FAIL accept_timeout: got stalls %0d expected <=200", stalls);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   st;
        int   tot_st;
        vec_t bad;
        tbl[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[1]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
        tbl[2]  = '{32'hFE000CE3, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 32'hFFFFFFF8, 1'b0};
        tbl[3]  = '{32'h123450B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0, 32'h12345000, 1'b0};
        tbl[4]  = '{32'h001000EF, 3'd4, 32'h00000800, 64'h0000000000000800, 1'b0, 32'h00000800, 1'b0};
        tbl[5]  = '{32'h03F01093, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0, 32'h0000001F, 1'b0};
        tbl[6]  = '{32'hFFF0D093, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0, 32'h0000001F, 1'b0};
        tbl[7]  = '{32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 32'h80000000, 1'b0};
        tbl[8]  = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0, 32'h000007FF, 1'b0};
        tbl[9]  = '{32'h00000033, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1, 32'h00000000, 1'b1};
        tbl[10] = '{32'hFFF00093, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{32'h80002003, 3'd0, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0, 32'hFFFFF800, 1'b0};
        tbl[12] = '{32'hFE112E23, 3'd0, 32'hFFFFFFE1, 64'hFFFFFFFFFFFFFFE1, 1'b0, 32'hFFFFFFFC, 1'b0};
        tbl[13] = '{32'h00001017, 3'd3, 32'h00001000, 64'h0000000000001000, 1'b0, 32'h00001000, 1'b0};
        tbl[14] = '{32'hFFC08067, 3'd0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
        tbl[15] = '{32'h00100073, 3'd0, 32'h00000001, 64'h0000000000000001, 1'b0, 32'h00000001, 1'b0};
        tbl[16] = '{32'h4010D093, 3'd0, 32'h00000401, 64'h0000000000000401, 1'b0, 32'h00000001, 1'b0};
        tbl[17] = '{32'hFFFFF06F, 3'd4, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 32'hFFFFFFFE, 1'b0};
        tbl[18] = '{32'h00000463, 3'd2, 32'h00000008, 64'h0000000000000008, 1'b0, 32'h00000008, 1'b0};
        tbl[19] = '{32'h123450B7, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1, 32'h12345000, 1'b0};
        bad     = '{32'h00000033, 3'd6, 32'h0, 64'h0, 1'b1, 32'h0, 1'b1};

        // Reset state, with inputs active to show they are ignored.
        in_valid = 1'b1; instruction = 32'hFFF00093;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", {61'b0, v32, v64, vau}, 64'd0);
        chk("rst_imm_data", imm64 | {32'b0, imm32}, 64'd0);
        chk("rst_tag_ill", {52'b0, tag32, tagau, ill32, ill64}, 64'd0);
        chk("rst_cnt", {16'b0, cnt32, cnt64, cntau}, 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {61'b0, rdy32, rdy64, rdyau}, 64'd7);
        chk("post_rst_no_output", {63'b0, v32}, 64'd0);

        // Pass 1: out_ready high, must accept one per cycle.
        or_mode = 1;
        @(posedge clk); #1;
        tot_st = 0;
        for (int i = 0; i < 20; i++) begin
            send(tbl[i], 5'(i), st);
            tot_st += st;
            if (i == 0) chk("latency_one_cycle", {63'b0, v32}, 64'd1);
        end
        chk("full_throughput_stalls", 64'(tot_st), 64'd0);
        drain();

        // Pass 2: random backpressure.
        or_mode = 2;
        for (int i = 0; i < 20; i++) send(tbl[i], 5'(i + 8), st);
        or_mode = 1;
        drain();
        // tbl 9,10,19 illegal for fixed-format; tbl 9 only for auto, two passes each
        chk("cnt32_after_table", {48'b0, cnt32}, 64'd6);
        chk("cnt64_after_table", {48'b0, cnt64}, 64'd6);
        chk("cntau_after_table", {48'b0, cntau}, 64'd2);

        // Backpressure: two accepts fill R0/R1, third is held.
        or_mode = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(tbl[0], 5'd1, st);
        send(tbl[1], 5'd2, st);
        @(negedge clk);
        chk("bp_in_ready_low", {63'b0, rdy32}, 64'd0);
        chk("bp_head_tag", {58'b0, v32, tag32}, {58'b0, 1'b1, 5'd1});
        fork
            send(tbl[2], 5'd3, st);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_hold_stable", {26'b0, v32, tag32, imm32}, {26'b0, 1'b1, 5'd1, 32'hFFFFFFFF});
                or_mode = 1;
            end
        join
        chk("bp_third_stalled", 64'(st > 0), 64'd1);
        drain();

        // Reset with R0 and R1 both full.
        or_mode = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(tbl[3], 5'd4, st);
        send(tbl[9], 5'd5, st);
        @(negedge clk);
        chk("pre_rst_full", {62'b0, v32, rdy32}, 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {61'b0, v32, v64, vau}, 64'd0);
        chk("mid_rst_cnt", {16'b0, cnt32, cnt64, cntau}, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        or_mode = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst2_ready_idle", {62'b0, rdy32, v32}, 64'd2);
        end
        @(posedge clk); #1;

        // Single illegal, then saturate the counter.
        send(bad, 5'd7, st);
        drain();
        chk("ill_cnt_one", {16'b0, cnt32, cnt64, cntau}, {16'b0, 16'd1, 16'd1, 16'd1});
        for (int i = 0; i < 65540; i++) send(bad, 5'(i), st);
        drain();
        chk("ill_cnt_sat", {16'b0, cnt32, cnt64, cntau}, {16'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        send(bad, 5'd9, st);
        drain();
        chk("ill_cnt_stays_sat", {16'b0, cnt32, cnt64, cntau}, {16'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
